bus_arbiter: RTL
================

// Module: bus_arbiter
// PURPOSE
//  - Round-robin arbiter sharing one WIDTH-bit datapath bus among N requesters.
//  - Grants one requester at a time, then drives the granted requester's data onto the shared bus.
//  - Sits in front of the register-file write port and the memory-interface bus.
// PARAMETERS
//  - WIDTH     64  data bus width in bits
//  - N         4   number of requesters (2..16)
//  - MAX_HOLD  16  max consecutive BUSY cycles per grant (used only with ARB_TIMEOUT_EN)
// PORTS
//  - clk       in   1          rising-edge clock
//  - reset_n   in   1          asynchronous, active-low reset
//  - req       in   N          request; requester holds it high for the whole transfer
//  - in_data   in   N*WIDTH    requester data; slice i = in_data[i*WIDTH +: WIDTH]
//  - gnt       out  N          one-hot grant, registered
//  - owner     out  $clog2(N)  index of the granted requester, registered
//  - out_data  out  WIDTH      shared bus: in_data slice of owner while BUSY, else 0
//  - out_valid out  1          high exactly while state == BUSY
//  - timeout   out  1          one-cycle pulse on forced release (0 without ARB_TIMEOUT_EN)
// BEHAVIOUR
//  - Interface (decided): one clock, clk. reset_n is asynchronous, active-low.
//  - Reset values: state IDLE, gnt 0, owner 0, rr_ptr 0, out_valid 0, out_data 0, timeout 0.
//  - Reset mid-transfer drops gnt immediately (async); no partial state survives.
//  - FSM states: IDLE, BUSY, RELEASE.
//    - IDLE: if req != 0, pick the first set bit scanning rr_ptr, rr_ptr+1 .. mod N.
//      Register gnt/owner and go to BUSY. Latency: req sampled at edge t -> gnt high after edge t.
//    - BUSY: gnt/owner stay stable and out_valid = 1.
//      When req[owner] == 0 at an edge: go to RELEASE, clear gnt, rr_ptr <= (owner+1) mod N.
//    - RELEASE: one dead turnaround cycle (gnt 0, out_valid 0), then IDLE unconditionally.
//  - Minimum grant-to-grant spacing is 3 cycles: BUSY >= 1, RELEASE, IDLE.
//  - Requests arriving while BUSY/RELEASE are not lost; they are evaluated in the next IDLE.
//  - Simultaneous requests: the round-robin scan decides. The last owner has the lowest priority next time.
//  - Wrap-around: rr_ptr wraps from N-1 to 0. owner = N-1 must give rr_ptr = 0.
//  - Single requester with req held continuously: re-granted every 3 cycles, no starvation.
//  - out_data is combinational from registered owner/state; no path from req to out_data.
//  - req deasserted without a grant: ignored, no state change.
// CONFIGURATION
//  - Macro ARB_TIMEOUT_EN.
//  - When defined:
//    - hold_cnt counts BUSY cycles.
//    - On the MAX_HOLD-th BUSY cycle the FSM forces RELEASE exactly as a normal release (rr_ptr advances), and timeout pulses for 1 cycle.
//    - The evicted requester is banned: masked from arbitration until its req deasserts for at least 1 cycle.
//    - Normal release before the limit clears hold_cnt, with no pulse.
//  - When undefined: no counter, no ban mask; grant is held indefinitely and timeout is tied to 0.
// STRUCTURE
//  - Package arb_pkg:
//    - typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RELEASE} arb_state_t;
//    - function rr_pick(req, ptr) returning a one-hot grant.
//  - Sub-module bus_mux_onehot #(WIDTH, N): AND-OR one-hot bus mux (gnt & BUSY -> out_data).
//    It is built from the same per-bit mux style as the existing 2:1 bus muxes.
// TESTING (N=4, WIDTH=16)
//  - Reset: reset_n=0 mid-BUSY with gnt=4'b0010 -> gnt=0, out_valid=0 at once (no clk edge); rr_ptr=0.
//  - Single requester:
//    - Stimulus: req=4'b0100, in_data[2]=16'hCA35.
//    - gnt=4'b0100 next cycle, owner=2, out_data=16'hCA35, out_valid=1.
//    - After req drops: one RELEASE cycle with out_data=0.
//  - Round robin:
//    - Stimulus: req=4'b1111 held; each owner drops req for 1 cycle after 2 BUSY cycles.
//    - Grant order 0,1,2,3,0 with 3-cycle minimum spacing.
//  - Wrap:
//    - Stimulus: owner=3 releases while req=4'b1001.
//    - Next grant is 0, not 3.
//  - Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4):
//    - Stimulus: req=4'b0011 held.
//    - gnt 0 for 4 cycles, timeout pulse, RELEASE, then gnt 1.
//    - Requester 0 is not re-granted until its req toggles low.
//  - No timeout build: the same stimulus holds gnt=4'b0001 for 100 cycles, with timeout=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and the round-robin pick function for the bus arbiter.
package arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RELEASE} arb_state_t;

  // Widest requester vector the pick function handles.
  localparam int ARB_MAX_N = 16;

  // Returns a one-hot vector holding the first set bit of req found by scanning
  // ptr, ptr+1, ... modulo n. Returns zero when no bit below n is set.
  function automatic logic [ARB_MAX_N-1:0] rr_pick(input logic [ARB_MAX_N-1:0] req,
                                                   input logic [3:0]           ptr,
                                                   input int                   n);
    logic [ARB_MAX_N-1:0] g;
    logic                 found;
    int                   idx;
    logic [3:0]           sel;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      idx = (int'(ptr) + i) % n;
      sel = idx[3:0];
      if ((i < n) && !found && req[sel]) begin
        g[sel] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/bus_mux_onehot.sv
// AND-OR bus multiplexer driven by a one-hot (or all-zero) select.
// An all-zero select yields an all-zero bus.
module bus_mux_onehot #(
  parameter int WIDTH = 64,
  parameter int N     = 4
) (
  input  logic [N-1:0]       sel,
  input  logic [N*WIDTH-1:0] data,
  output logic [WIDTH-1:0]   y
);

  // Each slice is gated by its select bit and all slices are ORed together.
  always_comb begin
    y = '0;
    for (int i = 0; i < N; i++) begin
      y = y | (data[i*WIDTH +: WIDTH] & {WIDTH{sel[i]}});
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit bus among N requesters.
// Grant lifecycle: IDLE -> BUSY (held while req[owner]) -> RELEASE -> IDLE.
// Optional feature macro: ARB_TIMEOUT_EN (forced release after MAX_HOLD BUSY
// cycles, with the evicted requester banned until its req drops).
module bus_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic                 timeout
);

  localparam int OW = $clog2(N);

  if (N < 2 || N > ARB_MAX_N || MAX_HOLD < 1) begin : g_param_check
    $error("bus_arbiter: N must be 2..16 and MAX_HOLD at least 1");
  end

  arb_state_t           state_q, state_d;
  logic [N-1:0]         gnt_q, gnt_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [N-1:0]         req_eff;
  logic [ARB_MAX_N-1:0] req_w;
  logic [ARB_MAX_N-1:0] pick_w;
  logic [OW-1:0]        pick_idx;
  logic [OW-1:0]        ptr_next;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [N-1:0]  ban_q, ban_d;
  logic          timeout_q, timeout_d;
  assign req_eff = req & ~ban_q;
  assign timeout = timeout_q;
`else
  assign req_eff = req;
  assign timeout = 1'b0;
`endif

  // Round-robin candidate from the current pointer; index of the chosen requester.
  always_comb begin
    req_w           = '0;
    req_w[N-1:0]    = req_eff;
    pick_w          = rr_pick(req_w, 4'(rr_ptr_q), N);
    pick_idx        = '0;
    for (int i = 0; i < ARB_MAX_N; i++) begin
      if (pick_w[i]) pick_idx = OW'(i);
    end
    ptr_next = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;
  end

  // Next-state and grant logic for the three-state arbitration FSM.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = '0;
    timeout_d  = 1'b0;
    ban_d      = ban_q & req;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|req_eff) begin
          state_d = ARB_BUSY;
          gnt_d   = pick_w[N-1:0];
          owner_d = pick_idx;
        end
      end
      ARB_BUSY: begin
        if (!req[owner_q]) begin
          state_d  = ARB_RELEASE;
          gnt_d    = '0;
          rr_ptr_d = ptr_next;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_cnt_q == HW'(MAX_HOLD - 1)) begin
          state_d         = ARB_RELEASE;
          gnt_d           = '0;
          rr_ptr_d        = ptr_next;
          timeout_d       = 1'b1;
          ban_d[owner_q]  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
`endif
        end
      end
      ARB_RELEASE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Control registers; asynchronous reset clears any grant in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      ban_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      ban_q      <= ban_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign out_valid = (state_q == ARB_BUSY);

  bus_mux_onehot #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_mux (
    .sel  (gnt_q & {N{out_valid}}),
    .data (in_data),
    .y    (out_data)
  );

endmodule
